frame_flush_ctrl: RTL



---
 rtl/frame_flush_pkg.sv | 27 ++
 rtl/frame_flush_ctrl_ram.sv | 47 ++++
 rtl/frame_flush_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/frame_flush_pkg.sv
// frame_flush_pkg: shared FSM states, word width and pixel packing for the frame flush engine
//   WORD_W     - Avalon write-data width
//   MAX_CH_W   - widest supported colour channel
//   state_t    - flush FSM states
//   pack_pixel - zero-extends three channels into one word in r-high or b-high order
package frame_flush_pkg;

    localparam int WORD_W   = 32;
    localparam int MAX_CH_W = 10;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    function automatic logic [WORD_W-1:0] pack_pixel(
        input logic [MAX_CH_W-1:0] r,
        input logic [MAX_CH_W-1:0] g,
        input logic [MAX_CH_W-1:0] b,
        input int                  ch_w,
        input bit                  swap
    );
        logic [WORD_W-1:0] hi, mid, lo;
        hi  = WORD_W'(swap ? b : r);
        mid = WORD_W'(g);
        lo  = WORD_W'(swap ? r : b);
        return (hi << (2 * ch_w)) | (mid << ch_w) | lo;
    endfunction

endpackage

// File: rtl/frame_flush_ctrl_ram.sv
// pixel_bank_ram: two DEPTH-entry pixel banks, one write port and two registered read ports
//   clk, reset                    - clock, async active-high reset (clears read registers only)
//   wr_en/wr_bank/wr_idx/wr_data  - pixel write; out-of-range index ignored
//   rd_bank/rd_idx -> rd_data     - readback, 1-cycle latency, out-of-range reads 0
//   fl_en/fl_bank/fl_idx -> fl_data - flush read, updated only when fl_en, holds otherwise
module pixel_bank_ram #(
    parameter int CH_W  = 8,
    parameter int DEPTH = 102400,
    parameter int IDX_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [3*CH_W-1:0] rd_data,
    input  logic              fl_en,
    input  logic              fl_bank,
    input  logic [IDX_W-1:0]  fl_idx,
    output logic [3*CH_W-1:0] fl_data
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [3*CH_W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && 32'(wr_idx) < DEPTH)
            mem[wr_bank][wr_idx[AW-1:0]] <= wr_data;
    end

    // Flush data holds between fetches so the write word stays stable across stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            fl_data <= '0;
        end else begin
            rd_data <= 32'(rd_idx) < DEPTH ? mem[rd_bank][rd_idx[AW-1:0]] : '0;
            if (fl_en && 32'(fl_idx) < DEPTH)
                fl_data <= mem[fl_bank][fl_idx[AW-1:0]];
        end
    end

endmodule

// File: rtl/frame_flush_ctrl.sv
// frame_flush_ctrl: double-buffered pixel store that flushes each completed frame to alternating SDRAM framebuffers
//   clk, reset          - clock, async active-high reset
//   wr_en/wr_idx/wr_*   - pixel write into the fill bank
//   rd_idx -> rd_*      - fill-bank readback, 1-cycle latency
//   frame_ready         - fill bank complete; swaps banks and starts a flush when idle
//   busy/finished       - flush in progress / 1-cycle pulse after last word
//   overrun             - sticky: frame_ready arrived while not idle
//   sd_*                - Avalon-MM write master
module frame_flush_ctrl
    import frame_flush_pkg::*;
#(
    parameter int              CH_W     = 8,
    parameter int              DEPTH    = 102400,
    parameter int              IDX_W    = 17,
    parameter int              ADDR_W   = 26,
    parameter logic [ADDR_W-1:0] FB_BASE0 = '0,
    parameter logic [ADDR_W-1:0] FB_BASE1 = 26'h0200000,
    parameter bit              CH_SWAP  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CH_W-1:0]   wr_r,
    input  logic [CH_W-1:0]   wr_g,
    input  logic [CH_W-1:0]   wr_b,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CH_W-1:0]   rd_r,
    output logic [CH_W-1:0]   rd_g,
    output logic [CH_W-1:0]   rd_b,
    input  logic              frame_ready,
    output logic              busy,
    output logic              finished,
    output logic              overrun,
    output logic [ADDR_W-1:0] sd_address,
    output logic [WORD_W-1:0] sd_wdata,
    output logic              sd_write,
    input  logic              sd_waitrequest
);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt;
    logic               fill_bank, flush_bank, fb_sel;
    logic               accept, last;
    logic [ADDR_W-1:0]  base;
    logic [3*CH_W-1:0]  fl_data;

    pixel_bank_ram #(
        .CH_W  (CH_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_bank (fill_bank),
        .wr_idx  (wr_idx),
        .wr_data ({wr_r, wr_g, wr_b}),
        .rd_bank (fill_bank),
        .rd_idx  (rd_idx),
        .rd_data ({rd_r, rd_g, rd_b}),
        .fl_en   (state == FETCH),
        .fl_bank (flush_bank),
        .fl_idx  (cnt),
        .fl_data (fl_data)
    );

    assign accept = state == WRITE && !sd_waitrequest;
    assign last   = 32'(cnt) == DEPTH - 1;
    assign base   = fb_sel ? FB_BASE1 : FB_BASE0;

    always_comb begin
        state_nx   = state == IDLE  ? (frame_ready ? FETCH : IDLE)
                   : state == FETCH ? WRITE
                   : state == WRITE ? (!accept ? WRITE : last ? DONE : FETCH)
                   : IDLE;
        busy       = state == FETCH || state == WRITE;
        finished   = state == DONE;
        sd_write   = state == WRITE;
        sd_address = sd_write ? base + ADDR_W'({cnt, 2'b00}) : '0;
        sd_wdata   = sd_write ? pack_pixel(MAX_CH_W'(fl_data[3*CH_W-1:2*CH_W]),
                                           MAX_CH_W'(fl_data[2*CH_W-1:CH_W]),
                                           MAX_CH_W'(fl_data[CH_W-1:0]),
                                           CH_W, CH_SWAP) : '0;
    end

    // A write in the same cycle as the swap still sees the old fill_bank, so it joins the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_bank  <= 1'b0;
            flush_bank <= 1'b0;
            fb_sel     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;
            if (frame_ready && state == IDLE) begin
                flush_bank <= fill_bank;
                fill_bank  <= ~fill_bank;
            end
            if (frame_ready && state != IDLE)
                overrun <= 1'b1;
            if (accept)
                cnt <= last ? '0 : cnt + IDX_W'(1);
            if (state == DONE)
                fb_sel <= ~fb_sel;
        end
    end

endmodule
